// File: rtl/fpga_debug_console_if.sv
// Board-side bundle for the debug console: raw keys, switches and probe
// channels in; CPU enable, operand, step counter, channel select and
// seven-segment digits out.
//   master : board / top level (drives key_n, sw, probe)
//   slave  : console logic (drives cpu_en, operand, step_count, ch_sel, hex)
interface fpga_debug_console_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SW_W   = 10,
    parameter int unsigned N_CH   = 4
);
    logic [3:0]             key_n;
    logic [SW_W-1:0]        sw;
    logic [N_CH*DATA_W-1:0] probe;
    logic                   cpu_en;
    logic [DATA_W-1:0]      operand;
    logic [15:0]            step_count;
    logic [3:0]             ch_sel;
    logic [41:0]            hex;

    modport master (
        output key_n, sw, probe,
        input  cpu_en, operand, step_count, ch_sel, hex
    );

    modport slave (
        input  key_n, sw, probe,
        output cpu_en, operand, step_count, ch_sel, hex
    );
endinterface

// File: rtl/fpga_debug_console.sv
// Debug console: debounces KEY[3:1], runs a HALT/RUN clock-enable FSM with
// single-step, pages the hex display across probe channels and registers a
// sign-extended switch operand.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : console bundle (slave side), see fpga_debug_console_if
module fpga_debug_console #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SW_W      = 10,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    fpga_debug_console_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(DB_CYCLES);
    localparam int unsigned N_KEYS = 3;

    typedef enum logic {HALT = 1'b0, RUN = 1'b1} mode_t;

    // Index 0 = step (KEY1), 1 = run/halt toggle (KEY2), 2 = page (KEY3)
    logic [N_KEYS-1:0] w_press;

    // Per-key synchroniser, debounce counter and registered press detector
    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic             r_sync1, r_sync2, r_stable, r_stable_d, r_press;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1    <= 1'b1;
                r_sync2    <= 1'b1;
                r_stable   <= 1'b1;
                r_stable_d <= 1'b1;
                r_press    <= 1'b0;
                r_cnt      <= '0;
            end else begin
                r_sync1    <= bus.key_n[k+1];
                r_sync2    <= r_sync1;
                r_stable_d <= r_stable;
                r_press    <= r_stable_d & ~r_stable;
                if (r_sync2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_press[k] = r_press;
    end

    mode_t             r_mode, w_mode_next;
    logic              r_cpu_en, w_cpu_en_next;
    logic [15:0]       r_step_count;
    logic [3:0]        r_ch_sel;
    logic [DATA_W-1:0] r_operand, w_operand;
    logic [41:0]       r_hex;
    logic [DATA_W-1:0] w_sel;
    logic              w_unused;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Mode state register
    always_ff @(posedge clk) begin
        if (reset) r_mode <= HALT;
        else       r_mode <= w_mode_next;
    end

    // Next mode and clock enable; toggle wins over a coincident step
    always_comb begin
        w_mode_next   = r_mode;
        w_cpu_en_next = 1'b0;
        case (r_mode)
            HALT: begin
                if (w_press[1])      w_mode_next   = RUN;
                else if (w_press[0]) w_cpu_en_next = 1'b1;
            end
            RUN: begin
                if (w_press[1]) w_mode_next = HALT;
            end
            default: w_mode_next = HALT;
        endcase
        // Enable follows the mode being entered, so it drops on the mode edge
        if (w_mode_next == RUN) w_cpu_en_next = 1'b1;
    end

    // Sign-extend the switches into the operand width
    always_comb begin
        w_operand           = {DATA_W{bus.sw[SW_W-1]}};
        w_operand[SW_W-1:0] = bus.sw;
    end

    // Mux out the displayed probe channel
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (r_ch_sel == 4'(i)) w_sel = bus.probe[i*DATA_W +: DATA_W];
        end
    end

    // Key 0 and probe bits above [15:0] have no function here
    assign w_unused = ^{bus.key_n[0], w_sel};

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_en     <= 1'b0;
            r_step_count <= '0;
            r_ch_sel     <= '0;
            r_operand    <= '0;
            r_hex        <= {6{7'b1000000}};
        end else begin
            r_cpu_en     <= w_cpu_en_next;
            r_step_count <= r_step_count + 16'(r_cpu_en);
            r_operand    <= w_operand;
            if (w_press[2]) begin
                r_ch_sel <= (r_ch_sel == 4'(N_CH - 1)) ? 4'd0 : r_ch_sel + 4'd1;
            end
            r_hex <= {seg7(r_ch_sel),
                      seg7({3'b000, r_mode == RUN}),
                      seg7(w_sel[15:12]), seg7(w_sel[11:8]),
                      seg7(w_sel[7:4]),   seg7(w_sel[3:0])};
        end
    end

    assign bus.cpu_en     = r_cpu_en;
    assign bus.step_count = r_step_count;
    assign bus.ch_sel     = r_ch_sel;
    assign bus.operand    = r_operand;
    assign bus.hex        = r_hex;
endmodule
